// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parameterised VGA sync/blank generator whose pixel coordinates
//            lead the HS/VS/blank_n outputs by LOOKAHEAD pixel-clock stages.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_SYNC    = 88,
    parameter int   H_BACK    = 47,
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 40,
    parameter int   V_SYNC    = 3,
    parameter int   V_BACK    = 31,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 13,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   LOOKAHEAD = 2,
    parameter int   CW        = 11
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          pix_ce,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          coord_valid,
    output logic          HS,
    output logic          VS,
    output logic          blank_n,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int c_V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [CW-1:0] c_H_MAX    = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_MAX    = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_SYNC   = CW'(H_SYNC);
    localparam logic [CW-1:0] c_V_SYNC   = CW'(V_SYNC);
    localparam logic [CW-1:0] c_H_VIS_LO = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] c_H_VIS_HI = CW'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [CW-1:0] c_V_VIS_LO = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] c_V_VIS_HI = CW'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [CW-1:0] r_pixel_x;
    logic [CW-1:0] r_pixel_y;
    logic          r_coord_valid;
    logic          r_line_start;
    logic          r_frame_start;
    // Per stage: {blank_n, vs_active, hs_active}; index 0 is the coordinate stage.
    logic [2:0]    r_pipe [0:LOOKAHEAD];

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_vis;
    logic w_v_vis;
    logic w_vis;
    logic w_hs_act;
    logic w_vs_act;
    logic w_h_zero;
    logic w_v_zero;

    assign w_h_wrap = (r_h_cnt == c_H_MAX);
    assign w_v_wrap = (r_v_cnt == c_V_MAX);
    assign w_h_vis  = (r_h_cnt >= c_H_VIS_LO) && (r_h_cnt < c_H_VIS_HI);
    assign w_v_vis  = (r_v_cnt >= c_V_VIS_LO) && (r_v_cnt < c_V_VIS_HI);
    assign w_vis    = w_h_vis && w_v_vis;
    assign w_hs_act = (r_h_cnt < c_H_SYNC);
    assign w_vs_act = (r_v_cnt < c_V_SYNC);
    assign w_h_zero = (r_h_cnt == '0);
    assign w_v_zero = (r_v_cnt == '0);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_ce) begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + c_ONE;
            end else begin
                r_h_cnt <= r_h_cnt + c_ONE;
            end
        end
    end

    // Coordinates and the sync/blank delay line all advance on the same ce edge.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_coord_valid <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            for (int i = 0; i <= LOOKAHEAD; i++) begin
                r_pipe[i] <= 3'b000;
            end
        end else if (pix_ce) begin
            r_coord_valid <= w_vis;
            r_pixel_x     <= w_vis   ? (r_h_cnt - c_H_VIS_LO) : '0;
            r_pixel_y     <= w_v_vis ? (r_v_cnt - c_V_VIS_LO) : '0;
            r_pipe[0]     <= {w_vis, w_vs_act, w_hs_act};
            for (int i = 1; i <= LOOKAHEAD; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Strobes are not held across ce-low clocks, so they stay one clock wide.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= pix_ce && w_h_zero;
            r_frame_start <= pix_ce && w_h_zero && w_v_zero;
        end
    end

    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign coord_valid = r_coord_valid;
    assign HS          = r_pipe[LOOKAHEAD][0] ? HS_POL : ~HS_POL;
    assign VS          = r_pipe[LOOKAHEAD][1] ? VS_POL : ~VS_POL;
    assign blank_n     = r_pipe[LOOKAHEAD][2];
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed table-driven bench for vga_timing_gen (16x7 small mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int CW = 5;

    logic          vga_clk = 1'b0;
    logic          reset;
    logic          pix_ce;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          coord_valid;
    logic          HS;
    logic          VS;
    logic          blank_n;
    logic          line_start;
    logic          frame_start;

    int checks   = 0;
    int failures = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(2), .H_VISIBLE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_VISIBLE(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(2), .CW(CW)
    ) u_dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .coord_valid (coord_valid),
        .HS          (HS),
        .VS          (VS),
        .blank_n     (blank_n),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    typedef struct {
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic [15:0] w_obs;
    assign w_obs = {pixel_x, pixel_y, coord_valid, HS, VS, blank_n, line_start, frame_start};

    function automatic logic [15:0] pk(int px, int py, bit cv, bit hs, bit vs, bit bn, bit ls, bit fs);
        return {px[4:0], py[4:0], cv, hs, vs, bn, ls, fs};
    endfunction

    function automatic void add(int n, int px, int py, bit cv, bit hs, bit vs, bit bn, bit ls, bit fs);
        vec_t v;
        v.n   = n;
        v.exp = pk(px, py, cv, hs, vs, bn, ls, fs);
        tbl.push_back(v);
    endfunction

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check_vec(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {px,py,cv,hs,vs,bn,ls,fs}=%h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Holds reset for three clocks with the given ce level, then releases with ce=1.
    task automatic do_reset(bit ce);
        pix_ce = ce;
        reset  = 1'b1;
        repeat (3) tick();
        check_vec($sformatf("reset_state ce=%0d", ce), w_obs, pk(0, 0, 0, 1, 1, 0, 0, 0));
        reset  = 1'b0;
        pix_ce = 1'b1;
    endtask

    // Edge index n counts ce edges from reset release; vectors are sampled after edge n.
    task automatic run_table(int max_n);
        int n = 0;
        foreach (tbl[i]) begin
            if (tbl[i].n <= max_n) begin
                while (n <= tbl[i].n) begin
                    tick();
                    n++;
                end
                check_vec($sformatf("vec n=%0d", tbl[i].n), w_obs, tbl[i].exp);
            end
        end
    endtask

    initial begin
        int          fs_cnt, ls_cnt, hs_low, vs_low, cv_cnt, bn_cnt, bad_px, bad_bn;
        int          fs_first, fs_second;
        logic        cv_d1, cv_d2;
        logic [13:0] prev;
        int          hold_bad;

        reset  = 1'b1;
        pix_ce = 1'b0;

        //   n   px py cv hs vs bn ls fs
        add(  0, 0, 0, 0, 1, 1, 0, 1, 1);
        add(  1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(  2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(  5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(  6, 0, 0, 0, 1, 0, 0, 0, 0);
        add( 16, 0, 0, 0, 1, 0, 0, 1, 0);
        add( 17, 0, 0, 0, 1, 0, 0, 0, 0);
        add( 18, 0, 0, 0, 0, 1, 0, 0, 0);
        add( 38, 0, 0, 1, 1, 1, 0, 0, 0);
        add( 40, 2, 0, 1, 1, 1, 1, 0, 0);
        add( 45, 7, 0, 1, 1, 1, 1, 0, 0);
        add( 46, 0, 0, 0, 1, 1, 1, 0, 0);
        add( 47, 0, 0, 0, 1, 1, 1, 0, 0);
        add( 48, 0, 1, 0, 1, 1, 0, 1, 0);
        add( 50, 0, 1, 0, 0, 1, 0, 0, 0);
        add( 93, 7, 3, 1, 1, 1, 1, 0, 0);
        add( 94, 0, 3, 0, 1, 1, 1, 0, 0);
        add( 96, 0, 0, 0, 1, 1, 0, 1, 0);
        add(111, 0, 0, 0, 1, 1, 0, 0, 0);
        add(112, 0, 0, 0, 1, 1, 0, 1, 1);
        add(114, 0, 0, 0, 0, 0, 0, 0, 0);
        add(150, 0, 0, 1, 1, 1, 0, 0, 0);

        // Reset with ce low, then reset with ce high and walk the full table.
        do_reset(1'b0);
        do_reset(1'b1);
        run_table(1000);

        // Two full frames of continuous ce: pulse counts, widths and alignment.
        fs_cnt = 0; ls_cnt = 0; hs_low = 0; vs_low = 0; cv_cnt = 0; bn_cnt = 0;
        bad_px = 0; bad_bn = 0; fs_first = -1; fs_second = -1;
        cv_d1 = coord_valid; cv_d2 = 1'b0;
        for (int k = 0; k < 224; k++) begin
            cv_d2 = cv_d1;
            cv_d1 = coord_valid;
            tick();
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            if (line_start)   ls_cnt++;
            if (!HS)          hs_low++;
            if (!VS)          vs_low++;
            if (coord_valid)  cv_cnt++;
            if (blank_n)      bn_cnt++;
            if (!coord_valid && pixel_x != '0) bad_px++;
            if (k >= 1 && blank_n !== cv_d2) bad_bn++;
        end
        check_int("frame_start_count", fs_cnt, 2);
        check_int("frame_period", fs_second - fs_first, 112);
        check_int("line_start_count", ls_cnt, 14);
        check_int("hs_low_clocks", hs_low, 56);
        check_int("vs_low_clocks", vs_low, 32);
        check_int("coord_valid_clocks", cv_cnt, 64);
        check_int("blank_n_clocks", bn_cnt, 64);
        check_int("pixel_x_nonzero_outside", bad_px, 0);
        check_int("blank_n_vs_cv_delay2", bad_bn, 0);

        // Alternating ce: frame doubles to 224 clocks, everything holds on ce=0.
        do_reset(1'b1);
        fs_cnt = 0; ls_cnt = 0; hold_bad = 0; fs_first = -1; fs_second = -1;
        prev = w_obs[15:2];
        for (int k = 0; k < 448; k++) begin
            pix_ce = (k % 2 == 0);
            tick();
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            if (line_start) ls_cnt++;
            if (!pix_ce && (w_obs[15:2] !== prev || line_start || frame_start)) hold_bad++;
            prev = w_obs[15:2];
        end
        pix_ce = 1'b1;
        check_int("ce_alt_frame_period", fs_second - fs_first, 224);
        check_int("ce_alt_frame_start_count", fs_cnt, 2);
        check_int("ce_alt_line_start_count", ls_cnt, 14);
        check_int("ce_alt_hold_violations", hold_bad, 0);

        // Reset pulse mid-frame at h=9, v=3, then the start-up sequence again.
        do_reset(1'b1);
        repeat (57) tick();
        check_vec("pre_midreset_h8_v3", w_obs, pk(2, 1, 1, 1, 1, 1, 0, 0));
        reset = 1'b1;
        tick();
        check_vec("midreset_values", w_obs, pk(0, 0, 0, 1, 1, 0, 0, 0));
        reset = 1'b0;
        run_table(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
